fp_mant_divsqrt: RTL

Iterative radix-2 significand divider / square-root engine. It is the responder side of the FP execution enable/ready handshake for `fdiv` and `fsqrt`: it accepts a one-cycle `enable` request, iterates one result bit per cycle, and returns a one-cycle `ready` with a held result and sticky bit. It sits inside the FP execution unit, after operand unpacking and before rounding/packing, which consume `quo` and `sticky`.

---
 rtl/fp_mant_divsqrt_if.sv | 29 ++
 rtl/fp_mant_divsqrt.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fp_mant_divsqrt_if.sv
// Request/response bundle between the FP execution unit and the significand
// divide/sqrt engine. The execution unit is the master, the engine the slave.
interface fp_mant_divsqrt_if;
  // enable is a one-cycle strobe honoured only while the engine is idle; ready
  // is a one-cycle completion pulse, and quo/sticky hold until the next ready.
  logic        enable;
  logic        clear;
  logic        op_div;
  logic        op_sqrt;
  logic [1:0]  fmt;
  logic        sqrt_shift;
  logic [52:0] mant_a;
  logic [52:0] mant_b;
  logic        busy;
  logic        ready;
  logic [55:0] quo;
  logic        sticky;
  logic [1:0]  dbg_state;

  modport master (
    output enable, clear, op_div, op_sqrt, fmt, sqrt_shift, mant_a, mant_b,
    input  busy, ready, quo, sticky, dbg_state
  );

  modport slave (
    input  enable, clear, op_div, op_sqrt, fmt, sqrt_shift, mant_a, mant_b,
    output busy, ready, quo, sticky, dbg_state
  );
endinterface

// File: rtl/fp_mant_divsqrt.sv
// Radix-2 restoring significand divider / square root, one result bit per cycle.
// Division and sqrt share the remainder, root/quotient and compare-subtract path.
module fp_mant_divsqrt (
  input  logic               clock,
  input  logic               reset,
  fp_mant_divsqrt_if.slave   io
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_sqrt_q, is_sqrt_d;
  logic [52:0] div_q, div_d;
  logic [55:0] rad_q, rad_d;
  logic [59:0] rem_q, rem_d;
  logic [55:0] root_q, root_d;
  logic [55:0] quo_q, quo_d;
  logic        sticky_q, sticky_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic [53:0] a_ext;
  logic [59:0] cand;
  logic [59:0] trial;
  logic [59:0] r1;
  logic        ge;
  logic        unused_fmt_hi;

  assign unused_fmt_hi = io.fmt[1];
  assign a_ext = io.sqrt_shift ? {io.mant_a, 1'b0} : {1'b0, io.mant_a};

  // Sqrt pulls the next two radicand bits into the remainder and tries 4*root+1;
  // division compares the (already doubled) remainder against the divisor.
  assign cand  = is_sqrt_q ? {rem_q[57:0], rad_q[55:54]} : rem_q;
  assign trial = is_sqrt_q ? {2'b00, root_q, 2'b01} : {7'b0, div_q};
  assign ge    = (cand >= trial);
  assign r1    = ge ? (cand - trial) : cand;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_sqrt_d = is_sqrt_q;
    div_d     = div_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    quo_d     = quo_q;
    sticky_d  = sticky_q;
    busy_d    = 1'b0;
    ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (io.enable) begin
          if (io.op_div ^ io.op_sqrt) begin
            state_d   = S_BUSY;
            busy_d    = 1'b1;
            cnt_d     = io.fmt[0] ? 6'd55 : 6'd26;
            is_sqrt_d = io.op_sqrt;
            div_d     = io.mant_b;
            // Radicand is top-aligned so the first pair consumed is the MSB pair.
            rad_d     = io.fmt[0] ? {a_ext, 2'b00} : {a_ext[24:0], 31'b0};
            rem_d     = io.op_sqrt ? 60'd0 : {7'b0, io.mant_a};
            root_d    = 56'd0;
          end else begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            quo_d    = 56'd0;
            sticky_d = 1'b0;
          end
        end
      end

      S_BUSY: begin
        root_d = {root_q[54:0], ge};
        rad_d  = {rad_q[53:0], 2'b00};
        rem_d  = is_sqrt_q ? r1 : {r1[58:0], 1'b0};
        if (cnt_q == 6'd0) begin
          state_d  = S_DONE;
          ready_d  = 1'b1;
          quo_d    = {root_q[54:0], ge};
          sticky_d = |r1;
        end else begin
          cnt_d  = cnt_q - 6'd1;
          busy_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort keeps the last completed result visible.
    if (io.clear) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      ready_d  = 1'b0;
      quo_d    = quo_q;
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      is_sqrt_q <= 1'b0;
      div_q     <= 53'd0;
      rad_q     <= 56'd0;
      rem_q     <= 60'd0;
      root_q    <= 56'd0;
      quo_q     <= 56'd0;
      sticky_q  <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_sqrt_q <= is_sqrt_d;
      div_q     <= div_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      quo_q     <= quo_d;
      sticky_q  <= sticky_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign io.busy      = busy_q;
  assign io.ready     = ready_q;
  assign io.quo       = quo_q;
  assign io.sticky    = sticky_q;
  assign io.dbg_state = state_q;
endmodule
